if_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the five-stage core. It replaces the single-cycle PC/ROM fetch with a decoupled unit. The unit issues in-order requests to an instruction memory with variable latency and buffers fetched words in a DEPTH-entry queue. It presents `{pc, instr}` to the IF/ID register through a valid/ready handshake, and it discards in-flight fetches when a branch or jump redirects the PC.

---
 rtl/core_pkg.sv | 14 +
 rtl/sync_fifo.sv | 73 +++++++
 rtl/if_fetch_queue.sv | 108 ++++++++++
 tb/tb_if_fetch_queue.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: widths, the NOP encoding, the fetch step
// and the {pc, instr} bundle handed from fetch to decode.
package core_pkg;

    localparam int DEF_XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int INSTR_STEP = 4;

    typedef struct packed {
        logic [DEF_XLEN-1:0] pc;
        logic [31:0]         instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with clear; head and occupancy are
// taken straight from registers.
module sync_fifo #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clear,
    input  logic [WIDTH-1:0]       i_din,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_nempty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_nempty;
    logic [CW-1:0]    w_cnt_nxt;

    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        w_cnt_nxt = r_count;
        if (i_push && !i_pop) begin
            w_cnt_nxt = r_count + CW'(1);
        end else if (i_pop && !i_push) begin
            w_cnt_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_nempty <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RST_VAL;
            end
        end else if (i_clear) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_nempty <= 1'b0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= f_inc(r_wptr);
            end
            if (i_pop) begin
                r_rptr <= f_inc(r_rptr);
            end
            r_count  <= w_cnt_nxt;
            r_nempty <= (w_cnt_nxt != '0);
        end
    end

    assign o_head   = r_mem[r_rptr];
    assign o_count  = r_count;
    assign o_nempty = r_nempty;

endmodule

// File: rtl/if_fetch_queue.sv
// Decoupled instruction fetch: credit-limited in-order requests,
// a tag FIFO of in-flight PCs and a queue feeding IF/ID.
module if_fetch_queue
    import core_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   id_valid,
    output logic [XLEN-1:0]        id_pc,
    output logic [31:0]            id_instr,
    input  logic                   id_ready,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int EW = XLEN + 32;
    localparam logic [EW-1:0] ENTRY_RST = {{XLEN{1'b0}}, NOP_INSTR};

    logic [XLEN-1:0]          r_fetch_pc;
    logic [OW-1:0]            r_discard;
    logic [XLEN-1:0]          w_tag;
    logic [$clog2(MAX_OUT):0] w_tag_cnt;
    logic                     w_tag_nempty;
    logic [EW-1:0]            w_head;
    int                       w_out;
    logic                     w_grant;
    logic                     w_drop;
    logic                     w_accept;
    logic                     w_pop;

    // Live tags plus pending drops is exactly the in-flight count.
    assign w_out = int'(w_tag_cnt) + int'(r_discard);

    assign imem_req = rst && !redirect && (w_out < MAX_OUT)
                   && (w_out + int'(occupancy) < DEPTH);
    assign imem_addr = r_fetch_pc;

    assign w_grant  = imem_req && imem_gnt;
    assign w_drop   = imem_rvalid && !redirect && (r_discard != '0);
    assign w_accept = imem_rvalid && !redirect && (r_discard == '0)
                   && w_tag_nempty;
    assign w_pop    = id_valid && id_ready && !redirect;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_discard  <= '0;
        end else if (redirect) begin
            r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            r_discard  <= OW'(w_out - int'(imem_rvalid));
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(INSTR_STEP);
            end
            if (w_drop) begin
                r_discard <= r_discard - OW'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH   (XLEN),
        .DEPTH   (MAX_OUT),
        .RST_VAL ('0)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_grant),
        .i_pop    (w_accept),
        .i_clear  (redirect),
        .i_din    (r_fetch_pc),
        .o_head   (w_tag),
        .o_count  (w_tag_cnt),
        .o_nempty (w_tag_nempty)
    );

    sync_fifo #(
        .WIDTH   (EW),
        .DEPTH   (DEPTH),
        .RST_VAL (ENTRY_RST)
    ) u_data_q (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_accept),
        .i_pop    (w_pop),
        .i_clear  (redirect),
        .i_din    ({w_tag, imem_rdata}),
        .o_head   (w_head),
        .o_count  (occupancy),
        .o_nempty (id_valid)
    );

    assign id_pc    = w_head[EW-1:32];
    assign id_instr = w_head[31:0];

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: variable-latency memory model
// and an in-order scoreboard of expected {pc, instr} deliveries.
module tb_if_fetch_queue;
    import core_pkg::*;

    localparam int XLEN = 32;
    localparam int DEPTH = 4;
    localparam int MAX_OUT = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready;
    logic [2:0]  occupancy;

    int vecs = 0;
    int errs = 0;
    int mem_k = 1;
    fetch_entry_t sb[$];

    typedef struct {
        logic [31:0] a;
        int          due;
    } pend_t;
    pend_t pq[$];

    if_fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .id_ready    (id_ready),
        .occupancy   (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    // Memory: grant every request, answer in order k edges later.
    initial begin
        int ecount;
        int last_due;
        int d;
        ecount = 0;
        last_due = 0;
        imem_gnt = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                pq.delete();
            end else begin
                if (imem_rvalid && pq.size() > 0) begin
                    void'(pq.pop_front());
                end
                if (imem_req && imem_gnt) begin
                    d = ecount + mem_k;
                    if (d <= last_due) d = last_due + 1;
                    pq.push_back('{imem_addr, d});
                    last_due = d;
                end
            end
            ecount++;
            #1;
            if (pq.size() > 0 && pq[0].due == ecount) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pq[0].a);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_fill(input logic [31:0] start, input int n);
        fetch_entry_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = mem_word(e.pc);
            sb.push_back(e);
        end
    endtask

    // Advance one cycle; a handshake seen before the edge is scored.
    task automatic nxt();
        logic hs;
        fetch_entry_t got;
        fetch_entry_t e;
        hs = rst && id_valid && id_ready && !redirect;
        got.pc = id_pc;
        got.instr = id_instr;
        @(negedge clk);
        if (hs) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_pc", got.pc, e.pc);
                chk("sb_instr", got.instr, e.instr);
            end
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !id_valid; i++) nxt();
        chk(tag, 32'(id_valid), 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b0;
        repeat (3) nxt();

        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_instr", id_instr, NOP_INSTR);
        chk("rst_occ", 32'(occupancy), 32'd0);

        rst = 1'b1;
        id_ready = 1'b1;
        sb_fill(RESET_PC, 40);
        #1;
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RESET_PC);
        nxt();
        chk("lat_k1", 32'(id_valid), 32'd0);
        nxt();
        chk("st_valid", 32'(id_valid), 32'd1);
        chk("st_pc0", id_pc, 32'h0);
        chk("st_instr0", id_instr, mem_word(32'h0));
        nxt();
        chk("st_pc4", id_pc, 32'h4);
        nxt();
        chk("st_pc8", id_pc, 32'h8);
        nxt();
        chk("st_pc12", id_pc, 32'hC);

        id_ready = 1'b0;
        repeat (10) nxt();
        chk("stall_occ", 32'(occupancy), 32'd4);
        chk("stall_req", 32'(imem_req), 32'd0);
        chk("stall_head", id_pc, 32'hC);
        id_ready = 1'b1;
        repeat (8) nxt();

        mem_k = 3;
        repeat (6) nxt();
        redirect = 1'b1;
        redirect_pc = 32'h100;
        sb.delete();
        nxt();
        redirect = 1'b0;
        sb_fill(32'h100, 40);
        chk("rd_valid0", 32'(id_valid), 32'd0);
        chk("rd_occ0", 32'(occupancy), 32'd0);
        wait_valid("rd_wait");
        chk("rd_pc", id_pc, 32'h100);
        repeat (4) nxt();

        mem_k = 1;
        repeat (6) nxt();
        chk("edge_rvalid", 32'(imem_rvalid), 32'd1);
        chk("edge_popv", 32'(id_valid), 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h300;
        sb.delete();
        nxt();
        chk("edge_v1", 32'(id_valid), 32'd0);
        redirect_pc = 32'h202;
        nxt();
        redirect = 1'b0;
        sb_fill(32'h200, 40);
        #1;
        chk("edge_req", 32'(imem_req), 32'd1);
        chk("edge_addr", imem_addr, 32'h200);
        chk("edge_v2", 32'(id_valid), 32'd0);
        nxt();
        chk("edge_t2", 32'(id_valid), 32'd0);
        nxt();
        chk("edge_t3", 32'(id_valid), 32'd1);
        chk("edge_pc", id_pc, 32'h200);
        repeat (3) nxt();

        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        sb.delete();
        nxt();
        redirect = 1'b0;
        sb_fill(32'hFFFF_FFF8, 40);
        wait_valid("wrap_wait");
        chk("wrap_pc0", id_pc, 32'hFFFF_FFF8);
        nxt();
        chk("wrap_pc1", id_pc, 32'hFFFF_FFFC);
        nxt();
        chk("wrap_pc2", id_pc, 32'h0);
        nxt();

        rst = 1'b0;
        sb.delete();
        nxt();
        chk("mrst_valid", 32'(id_valid), 32'd0);
        chk("mrst_occ", 32'(occupancy), 32'd0);
        chk("mrst_req", 32'(imem_req), 32'd0);
        chk("mrst_addr", imem_addr, RESET_PC);
        rst = 1'b1;
        sb_fill(RESET_PC, 40);
        wait_valid("mrst_wait");
        chk("mrst_pc", id_pc, RESET_PC);
        repeat (4) nxt();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
